// File: rtl/rmio_pkg.sv
// Shared constants for the RMIO execution-unit endpoint.
package rmio_pkg;

   // Bit positions inside the sticky err vector.
   localparam int unsigned ERR_OVF  = 0;
   localparam int unsigned ERR_UNF  = 1;
   localparam int unsigned ERR_MHOT = 2;
   localparam int unsigned ERR_W    = 3;

   // Default port geometry: 176-byte rows, four lanes.
   localparam int unsigned RMIO_DATA_W = 1408;
   localparam int unsigned RMIO_LANES  = 4;

endpackage

// File: rtl/rmio_lane_fifo.sv
// Single-lane FIFO: synchronous write, combinational head, extra-bit pointers.
// DEPTH_W must be at least 1. A push while full is accepted only when a pop
// happens in the same cycle; a pop while empty is ignored.
module rmio_lane_fifo
   import rmio_pkg::*;
#(
   parameter int unsigned DATA_W  = RMIO_DATA_W,
   parameter int unsigned DEPTH_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty,
   output logic [DEPTH_W:0]  level
);

   localparam int unsigned DEPTH = 2 ** DEPTH_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH_W:0]  wr_ptr_q, wr_ptr_d;
   logic [DEPTH_W:0]  rd_ptr_q, rd_ptr_d;
   logic              do_push, do_pop;

   // Status flags, accepted operations and next pointers.
   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[DEPTH_W] != rd_ptr_q[DEPTH_W]) &&
                 (wr_ptr_q[DEPTH_W-1:0] == rd_ptr_q[DEPTH_W-1:0]);
      level    = wr_ptr_q - rd_ptr_q;
      do_pop   = pop && !empty;
      // When full, the slot being written is the one being popped this cycle.
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q + {{DEPTH_W{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{DEPTH_W{1'b0}}, do_pop};
      head     = mem[rd_ptr_q[DEPTH_W-1:0]];
   end

   // Pointer state; storage contents are deliberately left unreset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Row storage write.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_q[DEPTH_W-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/rmio_eu_port.sv
// RMIO execution-unit endpoint: per-lane input FIFOs (register file -> core)
// with a round-robin core-side arbiter, per-lane output FIFOs (core -> register
// file) served through a one-cycle read register, and sticky error flags.
module rmio_eu_port
   import rmio_pkg::*;
#(
   parameter int unsigned DATA_W  = RMIO_DATA_W,
   parameter int unsigned LANES   = RMIO_LANES,
   parameter int unsigned DEPTH_W = 2,
   localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   // Register-file side
   input  logic [LANES-1:0]               rmio_input_we,
   input  logic [DATA_W-1:0]              rmio_input_data,
   input  logic [LANES-1:0]               rmio_output_re,
   output logic [DATA_W-1:0]              rmio_output_data,
   // Core input side
   output logic                           in_valid,
   output logic [LANE_W-1:0]              in_lane,
   output logic [DATA_W-1:0]              in_data,
   input  logic                           in_ready,
   // Core output side
   input  logic                           out_valid,
   input  logic [LANE_W-1:0]              out_lane,
   input  logic [DATA_W-1:0]              out_data,
   output logic                           out_ready,
   // Status
   output logic [LANES*(DEPTH_W+1)-1:0]   in_level,
   output logic [ERR_W-1:0]               err,
   input  logic                           err_clr
);

   // Input FIFO bank
   logic [LANES-1:0]  in_push, in_pop, in_full, in_empty;
   logic [DATA_W-1:0] in_head [LANES];
   logic [DEPTH_W:0]  in_lvl  [LANES];

   // Output FIFO bank
   logic [LANES-1:0]  out_push, out_pop, out_full, out_empty;
   logic [DATA_W-1:0] out_head [LANES];
   logic [DEPTH_W:0]  out_lvl  [LANES];

   // Arbiter
   logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [LANE_W-1:0] in_sel;
   logic [LANE_W-1:0] arb_lane;
   int unsigned       arb_idx;
   logic              in_fire;

   // Core output decode
   logic [LANES-1:0]  out_hit;

   // Read path
   logic              rd_any, rd_mhot, rd_unf, rd_found;
   logic [LANE_W-1:0] rd_sel;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   // Errors
   logic              ovf_evt;
   logic [ERR_W-1:0]  err_q, err_d;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      rmio_lane_fifo #(
         .DATA_W  (DATA_W),
         .DEPTH_W (DEPTH_W)
      ) u_in_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (in_push[i]),
         .push_data (rmio_input_data),
         .pop       (in_pop[i]),
         .head      (in_head[i]),
         .full      (in_full[i]),
         .empty     (in_empty[i]),
         .level     (in_lvl[i])
      );

      rmio_lane_fifo #(
         .DATA_W  (DATA_W),
         .DEPTH_W (DEPTH_W)
      ) u_out_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (out_push[i]),
         .push_data (out_data),
         .pop       (out_pop[i]),
         .head      (out_head[i]),
         .full      (out_full[i]),
         .empty     (out_empty[i]),
         .level     (out_lvl[i])
      );

      assign in_level[i*(DEPTH_W+1) +: (DEPTH_W+1)] = in_lvl[i];
   end

   // Round-robin pick: first non-empty input lane starting at rr_ptr_q.
   always_comb begin
      in_sel   = '0;
      in_valid = 1'b0;
      arb_idx  = 0;
      arb_lane = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         arb_idx  = (32'(rr_ptr_q) + k) % LANES;
         arb_lane = LANE_W'(arb_idx);
         if (!in_valid && !in_empty[arb_lane]) begin
            in_valid = 1'b1;
            in_sel   = arb_lane;
         end
      end
      in_lane = in_sel;
      in_data = in_head[in_sel];
   end

   // Core pop, register-file pushes, overflow detection and pointer advance.
   always_comb begin
      in_fire = in_valid && in_ready;
      in_pop  = '0;
      if (in_fire) begin
         in_pop[in_sel] = 1'b1;
      end
      in_push = rmio_input_we;
      // A full lane that is also popped this cycle still takes the write.
      ovf_evt = |(rmio_input_we & in_full & ~in_pop);
      rr_ptr_d = rr_ptr_q;
      if (in_fire) begin
         rr_ptr_d = (in_sel == LANE_W'(LANES - 1)) ? '0 : in_sel + LANE_W'(1);
      end
   end

   // Core result push; out-of-range lanes are accepted and discarded.
   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         out_hit[k] = (out_lane == LANE_W'(k));
      end
      out_ready = !(|(out_hit & out_full));
      out_push  = out_hit & {LANES{out_valid && out_ready}};
   end

   // Read decode: lowest set strobe wins, empty lane returns zero.
   always_comb begin
      rd_any   = |rmio_output_re;
      rd_mhot  = (rmio_output_re & (rmio_output_re - LANES'(1))) != '0;
      rd_sel   = '0;
      rd_found = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         if (rmio_output_re[k] && !rd_found) begin
            rd_found = 1'b1;
            rd_sel   = LANE_W'(k);
         end
      end
      rd_unf  = rd_any && (out_lvl[rd_sel] == '0);
      out_pop = '0;
      if (rd_any) begin
         out_pop[rd_sel] = !out_empty[rd_sel];
      end
      rdata_d = rdata_q;
      if (rd_any) begin
         rdata_d = rd_unf ? '0 : out_head[rd_sel];
      end
   end

   // Sticky flags; a same-cycle set wins over err_clr.
   always_comb begin
      err_d = err_clr ? '0 : err_q;
      if (ovf_evt) begin
         err_d[ERR_OVF] = 1'b1;
      end
      if (rd_unf) begin
         err_d[ERR_UNF] = 1'b1;
      end
      if (rd_any && rd_mhot) begin
         err_d[ERR_MHOT] = 1'b1;
      end
   end

   // Arbiter pointer, read register and error state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         rdata_q  <= '0;
         err_q    <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign rmio_output_data = rdata_q;
   assign err              = err_q;

endmodule

// File: doc/rmio_eu_port.md
# rmio_eu_port

Execution-unit-side endpoint of the RMIO protocol. The register file drives it as a memory-mapped peripheral: it captures rows written to per-lane X addresses and serves rows read from per-lane Y addresses. It buffers traffic in per-lane FIFOs between the register file and a compute core. Each EU (STMM, LayerNorm, SiLU, attention) instantiates one port in front of its datapath.

## Interface
- `DATA_W`, default 1408: row width in bits (176 bytes).
- `LANES`, default 4: number of lanes; one X/Y address pair per lane.
- `DEPTH_W`, default 2: log2 of the per-lane FIFO depth (4 entries).

- `clk` in 1: single clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rmio_input_we` in LANES: per-lane write strobe, registered by the register file.
- `rmio_input_data` in DATA_W: write row, aligned with `rmio_input_we`.
- `rmio_output_re` in LANES: per-lane read strobe.
- `rmio_output_data` out DATA_W: read row, valid the cycle after `rmio_output_re`.
- `in_valid` out 1: the core-facing input FIFO head is available.
- `in_lane` out $clog2(LANES): lane of the head row.
- `in_data` out DATA_W: head row.
- `in_ready` in 1: core consumes the head.
- `out_valid` in 1: core offers a result row.
- `out_lane` in $clog2(LANES): destination lane of the result.
- `out_data` in DATA_W: result row.
- `out_ready` out 1: the destination output FIFO can accept the row.
- `in_level` out LANES*(DEPTH_W+1): occupancy of each input FIFO.
- `err` out 3: sticky error flags. Bit 0 is overflow, bit 1 is underflow, bit 2 is multi-hot `re`.
- `err_clr` in 1: synchronous clear of `err`.

## Operation
- Each lane has one input FIFO (RF→core) and one output FIFO (core→RF), each holding 2^DEPTH_W entries.
- **Writes**
  - Every lane with its `rmio_input_we` bit set pushes `rmio_input_data`. Multi-hot `we` is a legal broadcast.
  - A push to a full lane is dropped and sets `err[0]`, unless that lane is popped in the same cycle; in that case both the push and the pop happen.
- **Reads**
  - A one-hot `rmio_output_re` pops that lane's output FIFO into the `rmio_output_data` register.
  - If that FIFO is empty, the register loads '0 and `err[1]` sets.
  - On multi-hot `re`, only the lowest set lane is served and `err[2]` sets.
  - With no `re`, `rmio_output_data` holds its last value.
- **Core input**
  - A round-robin arbiter selects among non-empty input FIFOs.
  - `in_valid`, `in_lane` and `in_data` are combinational from the selected head.
  - On `in_valid && in_ready`, the selected head is popped and the pointer moves to lane+1 (mod LANES).
  - `in_lane` and `in_data` stay stable while `in_valid && !in_ready`, unless a lane with higher priority becomes non-empty. The core must not depend on stability across cycles where it is not ready.
- **Core output**
  - `out_ready` = !full[out_lane], with no bypass.
  - On `out_valid && out_ready`, `out_data` is pushed into lane `out_lane`.
  - `out_lane` ≥ LANES is ignored, and `out_ready` is 1 in that case.
- **Error flags**
  - `err` bits are set-dominant: if a set event and `err_clr` occur in the same cycle, the bit ends at 1.
- **Reset values**
  - All FIFO pointers are 0.
  - `rmio_output_data` is '0.
  - `err` is 0.
  - The arbiter pointer is 0.
  - Consequently `in_valid`=0, `in_level`=0, and `out_ready`=1.
  - FIFO storage is not reset.
- **Reset mid-operation**: all queued rows are discarded. Outputs return to their reset values asynchronously.

## Timing
- Write latency: a `rmio_input_we` edge at cycle N makes the row visible at `in_valid` in cycle N+1; `in_level` updates at N+1.
- Read latency: `rmio_output_re` at cycle N gives `rmio_output_data` at N+1. This is exactly one cycle, matching the register file's address-pipelined mux of `q`.
- Back-to-back reads of the same lane on consecutive cycles return consecutive entries.
- A core push at cycle N is readable by an `re` at N+1; that read returns data at N+2.
- Throughput: one `we` per lane per cycle, one `re` per cycle, one core pop and one core push per cycle, all concurrent.

## Structure
- Package `rmio_pkg` holds:
  - the `ERR_OVF`, `ERR_UNF` and `ERR_MHOT` bit-index constants;
  - the default `DATA_W` and `LANES` localparams.
- Sub-module `rmio_lane_fifo`:
  - parameters `DATA_W` and `DEPTH_W`;
  - synchronous write and asynchronous (combinational) head read;
  - `push`, `pop`, `full`, `empty` and `level` ports;
  - internal extra-bit pointers for the full/empty distinction;
  - simultaneous push and pop when full is legal.
- The top module holds 2×LANES instances, the round-robin arbiter, the read register and the error logic.

## Test plan
- **Reset**: assert `rst_n`=0 mid-traffic. Required: `in_valid`=0, `rmio_output_data`=0, `err`=0 immediately; after release, `out_ready`=1.
- **Write/consume**: `we`=4'b0010 with data A5…A5, then `we`=4'b0001 with 5A…5A. Required: `in_valid` at N+1 with `in_lane`=1 and `in_data`=A5…; after `in_ready`, `in_lane`=0 (round-robin wrap).
- **Overflow**: 5 writes to lane 2 with data 1..5 and `in_ready`=0. Required: `in_level[2]`=4 and `err[0]`=1; draining yields 1,2,3,4. Also, a push to a full lane together with a core pop of that lane is accepted with no error.
- **Read path**: core pushes 0x11 then 0x22 to lane 3; `re`=4'b1000 on two consecutive cycles. Required: `rmio_output_data`=0x11 at N+1 and 0x22 at N+2. A third `re` returns 0 and sets `err[1]`.
- **Multi-hot read and broadcast**: `re`=4'b0110 serves lane 1 only and sets `err[2]`. `we`=4'b1111 fills all four lanes with the same row.
- **Error clear**: `err_clr` in the same cycle as a new overflow leaves `err[0]`=1; a lone `err_clr` clears all flags.
